// File: rtl/timer32_poll_ctrl.sv
// Bus-master sequencer for the 32-bit timer peripheral: programs PERIOD, enables the
// timer, polls CONTROL for the TMR flag, counts events and disables the timer on completion.
module timer32_poll_ctrl #(
    parameter int EVW          = 16,
    parameter bit AUTO_RESTART = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            stop,
    input  logic [31:0]     period_in,
    input  logic [EVW-1:0]  target,
    input  logic [31:0]     t_dout,
    output logic [31:0]     t_din,
    output logic            t_wren,
    output logic            t_rden,
    output logic [1:0]      t_addr,
    output logic            tick,
    output logic [EVW-1:0]  events,
    output logic            running,
    output logic            done
);

    localparam logic [1:0] ADDR_PERIOD  = 2'b01;
    localparam logic [1:0] ADDR_CONTROL = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_PER,
        S_WR_CTL,
        S_POLL,
        S_HALT
    } state_t;

    state_t         state, state_nxt;
    logic [31:0]    period_lat, period_nxt;
    logic [EVW-1:0] target_lat, target_nxt;
    logic [EVW-1:0] events_nxt, events_inc;
    logic           done_nxt, tick_nxt;
    logic           stop_pend, stop_pend_nxt;
    logic           tmr_hit;
    logic           dout_unused;

    // Only the TMR flag of the CONTROL read-back matters here.
    assign tmr_hit     = t_dout[1];
    assign dout_unused = ^{t_dout[31:2], t_dout[0]};
    assign events_inc  = events + 1'b1;
    assign running     = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            period_lat <= '0;
            target_lat <= '0;
            events     <= '0;
            done       <= 1'b0;
            tick       <= 1'b0;
            stop_pend  <= 1'b0;
        end else begin
            state      <= state_nxt;
            period_lat <= period_nxt;
            target_lat <= target_nxt;
            events     <= events_nxt;
            done       <= done_nxt;
            tick       <= tick_nxt;
            stop_pend  <= stop_pend_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        period_nxt    = period_lat;
        target_nxt    = target_lat;
        events_nxt    = events;
        done_nxt      = AUTO_RESTART ? 1'b0 : done;
        tick_nxt      = 1'b0;
        stop_pend_nxt = stop_pend;
        t_wren        = 1'b0;
        t_rden        = 1'b0;
        t_addr        = 2'b00;
        t_din         = 32'd0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    period_nxt = period_in;
                    target_nxt = target;
                    events_nxt = '0;
                    done_nxt   = 1'b0;
                    state_nxt  = S_WR_PER;
                end
            end
            S_WR_PER: begin
                t_wren = 1'b1;
                t_addr = ADDR_PERIOD;
                t_din  = period_lat;
                if (stop) stop_pend_nxt = 1'b1;
                state_nxt = S_WR_CTL;
            end
            S_WR_CTL: begin
                t_wren = 1'b1;
                t_addr = ADDR_CONTROL;
                t_din  = 32'h1;
                if (stop) stop_pend_nxt = 1'b1;
                state_nxt = S_POLL;
            end
            S_POLL: begin
                // A stop that arrived while programming skips the read entirely.
                if (stop_pend) begin
                    state_nxt = S_HALT;
                end else begin
                    t_rden = 1'b1;
                    t_addr = ADDR_CONTROL;
                    if (tmr_hit) begin
                        tick_nxt   = 1'b1;
                        events_nxt = events_inc;
                        if (target_lat != '0 && events_inc == target_lat) begin
                            done_nxt = 1'b1;
                            if (AUTO_RESTART) events_nxt = '0;
                            else              state_nxt  = S_HALT;
                        end
                    end
                    if (stop) state_nxt = S_HALT;
                end
            end
            S_HALT: begin
                t_wren        = 1'b1;
                t_addr        = ADDR_CONTROL;
                t_din         = 32'd0;
                stop_pend_nxt = 1'b0;
                state_nxt     = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_timer32_poll_ctrl.sv
// Bench for timer32_poll_ctrl: two instances (halting and auto-restart) each driving a
// behavioural timer, checked against a transaction-queue reference model and directed vectors.
module tb_timer32_poll_ctrl;

    localparam int EVW = 4;
    localparam int N   = 2;

    logic                    clk = 1'b0;
    logic                    reset, start, stop;
    logic [31:0]             period_in;
    logic [EVW-1:0]          target;
    logic [N-1:0][31:0]      t_dout, t_din;
    logic [N-1:0]            t_wren, t_rden, tick, running, done, tm_en;
    logic [N-1:0][1:0]       t_addr;
    logic [N-1:0][EVW-1:0]   events;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    timer32_poll_ctrl #(.EVW(EVW), .AUTO_RESTART(1'b0)) u_ar0 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .period_in(period_in),
        .target(target), .t_dout(t_dout[0]), .t_din(t_din[0]), .t_wren(t_wren[0]),
        .t_rden(t_rden[0]), .t_addr(t_addr[0]), .tick(tick[0]), .events(events[0]),
        .running(running[0]), .done(done[0]));

    timer32_poll_ctrl #(.EVW(EVW), .AUTO_RESTART(1'b1)) u_ar1 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .period_in(period_in),
        .target(target), .t_dout(t_dout[1]), .t_din(t_din[1]), .t_wren(t_wren[1]),
        .t_rden(t_rden[1]), .t_addr(t_addr[1]), .tick(tick[1]), .events(events[1]),
        .running(running[1]), .done(done[1]));

    // Timer peripheral: flags TMR every period+1 enabled cycles; a CONTROL read clears it.
    for (genvar g = 0; g < N; g++) begin : g_tmr
        logic        en, tmr, tog, hit;
        logic [31:0] per, cnt;
        assign hit       = en && (cnt == per);
        assign tm_en[g]  = en;
        assign t_dout[g] = (t_rden[g] && t_addr[g] == 2'b10) ? {29'd0, tog, tmr, en} : 32'd0;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                en <= 1'b0; tmr <= 1'b0; tog <= 1'b0; per <= '0; cnt <= '0;
            end else if (t_wren[g]) begin
                case (t_addr[g])
                    2'b00: cnt <= t_din[g];
                    2'b01: per <= t_din[g];
                    2'b10: begin
                        en  <= t_din[g][0];
                        tmr <= t_din[g][1];
                        tog <= t_din[g][2];
                        cnt <= '0;
                    end
                    default: ;
                endcase
            end else begin
                if (en) cnt <= hit ? 32'd0 : cnt + 32'd1;
                if (hit) begin
                    tmr <= 1'b1;
                    tog <= ~tog;
                end else if (t_rden[g] && t_addr[g] == 2'b10) begin
                    tmr <= 1'b0;
                end
            end
        end
    end

    // Reference model: a queue of pending bus writes; an empty queue while active means polling.
    typedef struct packed {
        logic        wr;
        logic        rd;
        logic [1:0]  addr;
        logic [31:0] din;
        logic        last;
    } op_t;

    op_t mq     [N][4];
    int  mqn    [N];
    bit  m_act  [N];
    bit  m_pend [N];
    bit  m_tick [N];
    bit  m_done [N];
    int  m_ev   [N];
    int  m_tgt  [N];

    function automatic op_t mk_op(logic wr, logic rd, logic [1:0] addr, logic [31:0] din, logic last);
        op_t o;
        o.wr = wr; o.rd = rd; o.addr = addr; o.din = din; o.last = last;
        return o;
    endfunction

    task automatic push(int i, op_t o);
        mq[i][mqn[i]] = o;
        mqn[i]++;
    endtask

    task automatic pop(int i, output op_t o);
        o = mq[i][0];
        for (int k = 0; k < 3; k++) mq[i][k] = mq[i][k+1];
        mqn[i]--;
    endtask

    task automatic model_reset(int i);
        mqn[i] = 0; m_act[i] = 0; m_pend[i] = 0; m_tick[i] = 0; m_done[i] = 0;
        m_ev[i] = 0; m_tgt[i] = 0;
    endtask

    function automatic op_t model_bus(int i);
        if (!reset || !m_act[i] || (mqn[i] == 0 && m_pend[i])) return '0;
        if (mqn[i] > 0) return mq[i][0];
        return mk_op(1'b0, 1'b1, 2'b10, 32'd0, 1'b0);
    endfunction

    task automatic model_step(int i, bit st, bit sp, logic [31:0] dout, logic [31:0] per, logic [EVW-1:0] tgt);
        op_t o;
        bit  halt;
        m_tick[i] = 0;
        if (i == 1) m_done[i] = 0;
        if (!m_act[i]) begin
            if (st) begin
                m_act[i] = 1; m_tgt[i] = int'(tgt); m_ev[i] = 0; m_done[i] = 0;
                push(i, mk_op(1'b1, 1'b0, 2'b01, per, 1'b0));
                push(i, mk_op(1'b1, 1'b0, 2'b10, 32'd1, 1'b0));
            end
        end else if (mqn[i] > 0) begin
            pop(i, o);
            if (o.last) begin
                m_act[i] = 0; m_pend[i] = 0;
            end else if (sp) begin
                m_pend[i] = 1;
            end
        end else if (m_pend[i]) begin
            push(i, mk_op(1'b1, 1'b0, 2'b10, 32'd0, 1'b1));
        end else begin
            halt = sp;
            if (dout[1]) begin
                m_tick[i] = 1;
                m_ev[i]   = (m_ev[i] + 1) % (1 << EVW);
                if (m_tgt[i] != 0 && m_ev[i] == m_tgt[i]) begin
                    m_done[i] = 1;
                    if (i == 1) m_ev[i] = 0;
                    else        halt = 1;
                end
            end
            if (halt) push(i, mk_op(1'b1, 1'b0, 2'b10, 32'd0, 1'b1));
        end
    endtask

    task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // One clock cycle: bus checked mid-cycle, registered outputs checked on the next falling edge.
    task automatic step();
        logic [N-1:0][31:0] dsnap;
        bit st, sp, rs;
        logic [31:0] per;
        logic [EVW-1:0] tgt;
        op_t o;
        #1;
        for (int i = 0; i < N; i++) begin
            o = model_bus(i);
            chk($sformatf("bus%0d", i), {28'd0, t_wren[i], t_rden[i], t_addr[i], t_din[i]},
                {28'd0, o.wr, o.rd, o.addr, o.din});
        end
        dsnap = t_dout; st = start; sp = stop; rs = reset; per = period_in; tgt = target;
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (!rs) model_reset(i);
            else     model_step(i, st, sp, dsnap[i], per, tgt);
        end
        @(negedge clk);
        for (int i = 0; i < N; i++)
            chk($sformatf("outs%0d", i), {57'd0, running[i], tick[i], done[i], events[i]},
                {57'd0, m_act[i], m_tick[i], m_done[i], EVW'(m_ev[i])});
    endtask

    task automatic idle_all();
        start = 0; stop = 1;
        for (int s = 0; s < 8 && running != '0; s++) step();
        chk("idle_all", {62'd0, running}, 64'd0);
        stop = 0;
    endtask

    typedef struct packed {
        logic        rst, st, sp;
        logic        wr, rd;
        logic [1:0]  addr;
        logic [31:0] din;
        logic        run, tk, dn;
        logic [3:0]  ev;
    } vec_t;

    function automatic vec_t mkv(logic rst, logic st, logic wr, logic rd, logic [1:0] addr,
                                 logic [31:0] din, logic run, logic tk, logic dn, logic [3:0] ev);
        vec_t v;
        v.rst = rst; v.st = st; v.sp = 1'b0; v.wr = wr; v.rd = rd; v.addr = addr; v.din = din;
        v.run = run; v.tk = tk; v.dn = dn; v.ev = ev;
        return v;
    endfunction

    vec_t tbl[24];

    initial begin
        int nt, nd;
        bit found;

        // Reset held with start=1, then period 3 / target 4 run on the halting instance.
        for (int r = 0; r < 3; r++) tbl[r] = mkv(0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        tbl[3] = mkv(1, 1, 0, 0, 2'b00, 0, 1, 0, 0, 0);
        tbl[4] = mkv(1, 0, 1, 0, 2'b01, 3, 1, 0, 0, 0);
        tbl[5] = mkv(1, 0, 1, 0, 2'b10, 1, 1, 0, 0, 0);
        for (int k = 3; k <= 19; k++)
            tbl[k+3] = mkv(1, 0, 0, 1, 2'b10, 0, 1, (k >= 7 && (k - 7) % 4 == 0), (k == 19),
                           (k >= 7) ? 4'((k - 7) / 4 + 1) : 4'd0);
        tbl[23] = mkv(1, 0, 1, 0, 2'b10, 0, 0, 0, 1, 4);

        reset = 0; start = 0; stop = 0; period_in = 32'd3; target = 4'd4;
        for (int i = 0; i < N; i++) model_reset(i);
        @(negedge clk);

        for (int r = 0; r < 24; r++) begin
            reset = tbl[r].rst; start = tbl[r].st; stop = tbl[r].sp;
            #1;
            chk($sformatf("vec%0d_bus", r), {28'd0, t_wren[0], t_rden[0], t_addr[0], t_din[0]},
                {28'd0, tbl[r].wr, tbl[r].rd, tbl[r].addr, tbl[r].din});
            step();
            chk($sformatf("vec%0d_outs", r), {57'd0, running[0], tick[0], done[0], events[0]},
                {57'd0, tbl[r].run, tbl[r].tk, tbl[r].dn, tbl[r].ev});
        end
        idle_all();

        // Free-run at period 0: one tick per poll cycle, 4-bit counter wraps, no done.
        period_in = 0; target = 0; start = 1;
        step();
        start = 0;
        for (int s = 1; s <= 22; s++) begin
            step();
            if (s >= 4) begin
                chk($sformatf("freerun_ev_s%0d", s), 64'(events[0]), 64'((s - 3) % 16));
                chk($sformatf("freerun_tick_s%0d", s), 64'(tick[0]), 64'd1);
            end
        end
        chk("freerun_done", {62'd0, done}, 64'd0);
        idle_all();

        // Stop during the PERIOD write: CONTROL write, one silent cycle, then disable.
        period_in = 2; target = 3; start = 1;
        step();
        start = 0; stop = 1;
        step();
        stop = 0;
        step();
        #1;
        chk("stoppend_noread", {61'd0, t_wren[0], t_rden[0], t_addr[0][1]}, 64'd0);
        step();
        #1;
        chk("stoppend_halt", {28'd0, t_wren[0], t_rden[0], t_addr[0], t_din[0]},
            {28'd0, 1'b1, 1'b0, 2'b10, 32'd0});
        step();
        chk("stoppend_idle", {58'd0, running[0], events[0], done[0]}, 64'd0);
        idle_all();

        // TMR hit coinciding with stop while events==1.
        period_in = 1; target = 0; start = 1;
        step();
        start = 0;
        found = 0;
        for (int s = 0; s < 30 && !found; s++) begin
            #1;
            if (events[0] == 1 && t_dout[0][1]) found = 1;
            else step();
        end
        chk("tmr_stop_found", 64'(found), 64'd1);
        if (found) begin
            stop = 1;
            step();
            chk("tmr_stop_tick", {59'd0, tick[0], events[0]}, {59'd0, 1'b1, 4'd2});
            stop = 0;
            #1;
            chk("tmr_stop_halt", {28'd0, t_wren[0], t_rden[0], t_addr[0], t_din[0]},
                {28'd0, 1'b1, 1'b0, 2'b10, 32'd0});
            step();
            chk("tmr_stop_end", {62'd0, running[0], done[0]}, 64'd0);
        end
        idle_all();

        // Auto-restart instance: done pulses every second tick, timer stays enabled.
        period_in = 1; target = 2; start = 1;
        step();
        start = 0; nt = 0; nd = 0;
        for (int s = 1; s <= 30; s++) begin
            step();
            if (s >= 2) chk($sformatf("ar_enabled_s%0d", s), 64'(tm_en[1]), 64'd1);
            if (tick[1]) begin
                nt++;
                if (done[1]) nd++;
                chk($sformatf("ar_events_s%0d", s), 64'(events[1]), done[1] ? 64'd0 : 64'd1);
            end else begin
                chk($sformatf("ar_nodone_s%0d", s), 64'(done[1]), 64'd0);
            end
        end
        chk("ar_tick_count", 64'(nt >= 6), 64'd1);
        chk("ar_done_count", 64'(nd), 64'(nt / 2));
        idle_all();

        // Random traffic, including mid-operation resets.
        for (int s = 0; s < 500; s++) begin
            reset     = ($urandom % 60) != 0;
            start     = ($urandom % 4) == 0;
            stop      = ($urandom % 10) == 0;
            period_in = $urandom % 5;
            target    = EVW'($urandom % 6);
            step();
        end
        reset = 1;
        idle_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
